// File: rtl/demux_4w_1_to_2.sv
// Buffered 1-to-2 demultiplexer for 4-bit words with one FIFO per output channel.
// Optional macro DEMUX_BYPASS_EN: zero-latency cut-through into an empty, ready channel.
module demux_4w_1_to_2 #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 in_data,
  input  logic                       in_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [3:0]                 x_data,
  output logic                       x_valid,
  input  logic                       x_ready,
  output logic [3:0]                 y_data,
  output logic                       y_valid,
  input  logic                       y_ready,
  output logic [$clog2(DEPTH):0]     x_count,
  output logic [$clog2(DEPTH):0]     y_count,
  output logic                       proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);
  localparam logic [PW-1:0] ONE_PTR = PW'(1);

  logic [3:0]    x_mem [DEPTH];
  logic [3:0]    y_mem [DEPTH];
  logic [PW-1:0] x_wr, x_rd, y_wr, y_rd;
  logic          x_empty, y_empty;
  logic          accept;
  logic          x_bypass, y_bypass;
  logic          x_push, x_pop, y_push, y_pop;
  logic          pend_q;
  logic [3:0]    pend_data_q;
  logic          pend_sel_q;

  assign x_empty  = (x_count == '0);
  assign y_empty  = (y_count == '0);
  // Fullness alone decides readiness; a same-cycle pop never frees a slot early.
  assign in_ready = in_sel ? (x_count != FULL) : (y_count != FULL);
  assign accept   = in_valid & in_ready;

`ifdef DEMUX_BYPASS_EN
  assign x_bypass = in_valid & in_sel & x_empty & x_ready;
  assign y_bypass = in_valid & ~in_sel & y_empty & y_ready;
  assign x_valid  = ~x_empty | (in_valid & in_sel & x_empty);
  assign y_valid  = ~y_empty | (in_valid & ~in_sel & y_empty);
  assign x_data   = (x_empty & in_valid & in_sel) ? in_data : x_mem[x_rd];
  assign y_data   = (y_empty & in_valid & ~in_sel) ? in_data : y_mem[y_rd];
`else
  assign x_bypass = 1'b0;
  assign y_bypass = 1'b0;
  assign x_valid  = ~x_empty;
  assign y_valid  = ~y_empty;
  assign x_data   = x_mem[x_rd];
  assign y_data   = y_mem[y_rd];
`endif

  assign x_push = accept & in_sel & ~x_bypass;
  assign y_push = accept & ~in_sel & ~y_bypass;
  assign x_pop  = x_ready & ~x_empty;
  assign y_pop  = y_ready & ~y_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        x_mem[i] <= '0;
        y_mem[i] <= '0;
      end
      x_wr    <= '0;
      x_rd    <= '0;
      y_wr    <= '0;
      y_rd    <= '0;
      x_count <= '0;
      y_count <= '0;
    end else begin
      if (x_push) begin
        x_mem[x_wr] <= in_data;
        x_wr        <= x_wr + ONE_PTR;
      end
      if (x_pop) x_rd <= x_rd + ONE_PTR;
      case ({x_push, x_pop})
        2'b10:   x_count <= x_count + ONE_CNT;
        2'b01:   x_count <= x_count - ONE_CNT;
        default: x_count <= x_count;
      endcase

      if (y_push) begin
        y_mem[y_wr] <= in_data;
        y_wr        <= y_wr + ONE_PTR;
      end
      if (y_pop) y_rd <= y_rd + ONE_PTR;
      case ({y_push, y_pop})
        2'b10:   y_count <= y_count + ONE_CNT;
        2'b01:   y_count <= y_count - ONE_CNT;
        default: y_count <= y_count;
      endcase
    end
  end

  // A stalled word must be held unchanged until it is taken; any change is latched as an error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_sel_q  <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      pend_q      <= in_valid & ~in_ready;
      pend_data_q <= in_data;
      pend_sel_q  <= in_sel;
      if (pend_q && (!in_valid || in_data != pend_data_q || in_sel != pend_sel_q))
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_4w_1_to_2.sv
// Directed self-checking bench for demux_4w_1_to_2 (DEPTH = 4).
module tb_demux_4w_1_to_2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] x_data;
  logic       x_valid;
  logic       x_ready;
  logic [3:0] y_data;
  logic       y_valid;
  logic       y_ready;
  logic [2:0] x_count;
  logic [2:0] y_count;
  logic       proto_err;

  int n_compared   = 0;
  int n_mismatched = 0;

  demux_4w_1_to_2 #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
    .x_count(x_count), .y_count(y_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic sel, input logic [3:0] d);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
    x_ready = 1'b0; y_ready = 1'b0;
    #12;
    n_compared++;
    if (x_valid !== 1'b0 || y_valid !== 1'b0 || x_data !== 4'h0 || y_data !== 4'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs: got xv=%b yv=%b xd=%h yd=%h, expected all 0", x_valid, y_valid, x_data, y_data);
    end
    n_compared++;
    if (x_count !== 3'd0 || y_count !== 3'd0 || proto_err !== 1'b0 || in_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL reset_counts: got xc=%0d yc=%0d pe=%b rdy=%b, expected 0 0 0 1", x_count, y_count, proto_err, in_ready);
    end
    #2 reset = 1'b0;
    tick();
    push(1'b1, 4'hC);
    push(1'b1, 4'hD);
    n_compared++;
    if (x_count !== 3'd2) begin
      n_mismatched++;
      $display("[TB] FAIL pre_reset_fill: got x_count=%0d, expected 2", x_count);
    end
    #3 reset = 1'b1;
    #1;
    n_compared++;
    if (x_valid !== 1'b0 || x_count !== 3'd0 || proto_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset: got xv=%b xc=%0d pe=%b, expected 0 0 0", x_valid, x_count, proto_err);
    end
    #1 reset = 1'b0;
    tick();
    in_sel = 1'b1;
    #1;
    n_compared++;
    if (in_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL ready_after_reset: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_steering();
    x_ready = 1'b1; y_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 4'h5;
    #1;
`ifdef DEMUX_BYPASS_EN
    n_compared++;
    if (x_valid !== 1'b1 || x_data !== 4'h5) begin
      n_mismatched++;
      $display("[TB] FAIL steer_x_bypass: got xv=%b xd=%h, expected 1 5", x_valid, x_data);
    end
    tick();
    in_sel = 1'b0; in_data = 4'hA;
    #1;
    n_compared++;
    if (y_valid !== 1'b1 || y_data !== 4'hA || x_count !== 3'd0) begin
      n_mismatched++;
      $display("[TB] FAIL steer_y_bypass: got yv=%b yd=%h xc=%0d, expected 1 a 0", y_valid, y_data, x_count);
    end
    tick();
`else
    n_compared++;
    if (x_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL steer_x_latency: got x_valid=%b before edge, expected 0", x_valid);
    end
    tick();
    n_compared++;
    if (x_valid !== 1'b1 || x_data !== 4'h5 || x_count !== 3'd1) begin
      n_mismatched++;
      $display("[TB] FAIL steer_x: got xv=%b xd=%h xc=%0d, expected 1 5 1", x_valid, x_data, x_count);
    end
    in_sel = 1'b0; in_data = 4'hA;
    tick();
    n_compared++;
    if (y_valid !== 1'b1 || y_data !== 4'hA || x_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL steer_y: got yv=%b yd=%h xv=%b, expected 1 a 0", y_valid, y_data, x_valid);
    end
`endif
    in_valid = 1'b0;
    tick();
    n_compared++;
    if (y_valid !== 1'b0 || y_count !== 3'd0) begin
      n_mismatched++;
      $display("[TB] FAIL steer_drain: got yv=%b yc=%0d, expected 0 0", y_valid, y_count);
    end
  endtask

  task automatic test_full_independence();
    x_ready = 1'b0; y_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(1'b1, 4'(i));
    in_sel = 1'b1;
    #1;
    n_compared++;
    if (x_count !== 3'd4 || in_ready !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL x_full: got xc=%0d rdy=%b, expected 4 0", x_count, in_ready);
    end
    in_sel = 1'b0;
    #1;
    n_compared++;
    if (in_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL y_ready_while_x_full: got %b, expected 1", in_ready);
    end
    push(1'b0, 4'h3);
    n_compared++;
    if (y_valid !== 1'b1 || y_data !== 4'h3 || x_count !== 3'd4) begin
      n_mismatched++;
      $display("[TB] FAIL y_independent: got yv=%b yd=%h xc=%0d, expected 1 3 4", y_valid, y_data, x_count);
    end
    y_ready = 1'b1; x_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_compared++;
      if (x_valid !== 1'b1 || x_data !== 4'(i)) begin
        n_mismatched++;
        $display("[TB] FAIL x_drain_%0d: got xv=%b xd=%h, expected 1 %h", i, x_valid, x_data, 4'(i));
      end
      tick();
    end
    n_compared++;
    if (x_count !== 3'd0 || y_count !== 3'd0) begin
      n_mismatched++;
      $display("[TB] FAIL full_cleanup: got xc=%0d yc=%0d, expected 0 0", x_count, y_count);
    end
  endtask

  task automatic test_wrap_order();
    int sent = 1;
    int expect_word = 1;
    for (int cyc = 0; cyc < 100 && expect_word <= 9; cyc++) begin
      y_ready  = (cyc % 2 == 0);
      in_valid = (sent <= 9);
      in_sel   = 1'b0;
      in_data  = 4'(sent);
      #1;
      if (y_valid && y_ready) begin
        n_compared++;
        if (y_data !== 4'(expect_word)) begin
          n_mismatched++;
          $display("[TB] FAIL wrap_word_%0d: got %h, expected %h", expect_word, y_data, 4'(expect_word));
        end
        expect_word++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
      if (y_count > 3'd4) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL wrap_overflow: got y_count=%0d, expected <= 4", y_count);
      end
    end
    in_valid = 1'b0;
    n_compared++;
    if (expect_word !== 10 || y_count !== 3'd0) begin
      n_mismatched++;
      $display("[TB] FAIL wrap_complete: got next=%0d yc=%0d, expected 10 0", expect_word, y_count);
    end
    y_ready = 1'b1;
  endtask

  task automatic test_simultaneous();
    y_ready = 1'b0;
    push(1'b0, 4'h6);
    push(1'b0, 4'h7);
    y_ready = 1'b1;
    push(1'b0, 4'h8);
    n_compared++;
    if (y_count !== 3'd2 || y_data !== 4'h7) begin
      n_mismatched++;
      $display("[TB] FAIL push_pop_same: got yc=%0d yd=%h, expected 2 7", y_count, y_data);
    end
    y_ready = 1'b0;
    push(1'b0, 4'h9);
    push(1'b0, 4'hA);
    y_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'hB;
    #1;
    n_compared++;
    if (y_count !== 3'd4 || in_ready !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL full_no_write: got yc=%0d rdy=%b, expected 4 0", y_count, in_ready);
    end
    tick();
    n_compared++;
    if (y_count !== 3'd3 || in_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL full_pop_only: got yc=%0d rdy=%b, expected 3 1", y_count, in_ready);
    end
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_compared++;
      if (y_data !== 4'(9 + i) || y_valid !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL simul_order_%0d: got yv=%b yd=%h, expected 1 %h", i, y_valid, y_data, 4'(9 + i));
      end
      tick();
    end
    n_compared++;
    if (y_valid !== 1'b0 || proto_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL simul_end: got yv=%b pe=%b, expected 0 0", y_valid, proto_err);
    end
  endtask

  task automatic test_proto_err();
    x_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b1, 4'hE);
    in_valid = 1'b1; in_sel = 1'b1; in_data = 4'h7;
    tick();
    n_compared++;
    if (proto_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL proto_hold: got %b, expected 0", proto_err);
    end
    in_data = 4'h8;
    tick();
    n_compared++;
    if (proto_err !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL proto_set: got %b, expected 1", proto_err);
    end
    in_valid = 1'b0;
    x_ready = 1'b1;
    repeat (5) tick();
    n_compared++;
    if (proto_err !== 1'b1 || x_count !== 3'd0) begin
      n_mismatched++;
      $display("[TB] FAIL proto_sticky: got pe=%b xc=%0d, expected 1 0", proto_err, x_count);
    end
    #2 reset = 1'b1;
    #1;
    n_compared++;
    if (proto_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL proto_clear: got %b, expected 0", proto_err);
    end
    #1 reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_steering();
    test_full_independence();
    test_wrap_order();
    test_simultaneous();
    test_proto_err();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
